// File: rtl/usb_tx.sv
// usb_tx: full-speed USB transmit engine. Serialises SYNC, PID, payload and
// CRC16 with bit stuffing and NRZI, then EOP, onto dp_out/dm_out.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | line at J, waiting for a packet request
// S_SYNC    | sending 8'h80 LSB first
// S_PID     | sending {~pid, pid}
// S_DATA    | sending len payload bytes, CRC16 accumulating
// S_CRC     | sending ~crc, 16 bits LSB first
// S_EOP_SE0 | two bit times of SE0
// S_EOP_J   | one bit time of J, then back to IDLE
module usb_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int MAX_PAYLOAD  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] tx_packet,
  input  logic [6:0] buffer_occupancy,
  input  logic [7:0] tx_packet_data,
  output logic       get_tx_packet_data,
  output logic       tx_transfer_active,
  output logic       tx_error,
  output logic       dp_out,
  output logic       dm_out
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(CLKS_PER_BIT - 1);

  // kind of symbol driven for the next bit time
  localparam logic [1:0] K_DATA  = 2'd0;
  localparam logic [1:0] K_STUFF = 2'd1;
  localparam logic [1:0] K_SE0   = 2'd2;
  localparam logic [1:0] K_J     = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC, S_EOP_SE0, S_EOP_J
  } state_t;

  state_t        state;
  logic [CW-1:0] clk_cnt;
  logic [3:0]    bit_idx;
  logic [6:0]    len;
  logic [6:0]    bytes_left;
  logic [3:0]    pid;
  logic          is_data;
  logic [7:0]    shift;
  logic [15:0]   crc;
  logic [2:0]    ones;
  logic          lvl;

  logic [7:0]  pid_byte;
  logic [3:0]  nxt_idx;
  state_t      n_state;
  logic [3:0]  n_idx;
  logic        n_bit;
  logic [1:0]  n_kind;
  logic        n_pop;
  logic        n_crc;
  logic [15:0] crc_new;
  logic        req_legal;
  logic        req_data;
  logic [3:0]  req_pid;
  logic        in_stuff_span;

  // decode the incoming request
  always_comb begin
    req_legal = (tx_packet != 3'd0) && (tx_packet <= 3'd5);
    req_data  = (tx_packet == 3'd1) || (tx_packet == 3'd2);
    case (tx_packet)
      3'd1:    req_pid = 4'b0011;
      3'd2:    req_pid = 4'b1011;
      3'd3:    req_pid = 4'b0010;
      3'd4:    req_pid = 4'b1010;
      3'd5:    req_pid = 4'b1110;
      default: req_pid = 4'b0000;
    endcase
  end

  // choose what to drive at the end of the current bit time
  always_comb begin
    pid_byte = {~pid, pid};
    nxt_idx  = bit_idx + 4'd1;
    n_state  = state;
    n_idx    = bit_idx;
    n_bit    = 1'b0;
    n_kind   = K_DATA;
    n_pop    = 1'b0;
    n_crc    = 1'b0;
    in_stuff_span = (state == S_SYNC) || (state == S_PID) ||
                    (state == S_DATA) || (state == S_CRC);
    case (state)
      S_SYNC: begin
        if (bit_idx != 4'd7) begin
          n_idx = nxt_idx;
          n_bit = (bit_idx == 4'd6);
        end else begin
          n_state = S_PID;
          n_idx   = 4'd0;
          n_bit   = pid_byte[0];
        end
      end
      S_PID: begin
        if (bit_idx != 4'd7) begin
          n_idx = nxt_idx;
          n_bit = pid_byte[nxt_idx[2:0]];
        end else if (!is_data) begin
          n_state = S_EOP_SE0;
          n_idx   = 4'd0;
          n_kind  = K_SE0;
        end else if (len == 7'd0) begin
          n_state = S_CRC;
          n_idx   = 4'd0;
          n_bit   = ~crc[0];
        end else begin
          n_state = S_DATA;
          n_idx   = 4'd0;
          n_bit   = tx_packet_data[0];
          n_pop   = 1'b1;
          n_crc   = 1'b1;
        end
      end
      S_DATA: begin
        if (bit_idx != 4'd7) begin
          n_idx = nxt_idx;
          n_bit = shift[nxt_idx[2:0]];
          n_crc = 1'b1;
        end else if (bytes_left != 7'd0) begin
          n_idx = 4'd0;
          n_bit = tx_packet_data[0];
          n_pop = 1'b1;
          n_crc = 1'b1;
        end else begin
          n_state = S_CRC;
          n_idx   = 4'd0;
          n_bit   = ~crc[0];
        end
      end
      S_CRC: begin
        if (bit_idx != 4'd15) begin
          n_idx = nxt_idx;
          n_bit = ~crc[nxt_idx];
        end else begin
          n_state = S_EOP_SE0;
          n_idx   = 4'd0;
          n_kind  = K_SE0;
        end
      end
      S_EOP_SE0: begin
        if (bit_idx == 4'd0) begin
          n_idx  = 4'd1;
          n_kind = K_SE0;
        end else begin
          n_state = S_EOP_J;
          n_idx   = 4'd0;
          n_kind  = K_J;
        end
      end
      S_EOP_J: begin
        n_state = S_IDLE;
        n_idx   = 4'd0;
        n_kind  = K_J;
      end
      default: begin
        n_state = state;
      end
    endcase
    // a stuff bit holds position: no bit counter, CRC or pop advance
    if (in_stuff_span && (ones == 3'd6)) begin
      n_state = state;
      n_idx   = bit_idx;
      n_kind  = K_STUFF;
      n_pop   = 1'b0;
      n_crc   = 1'b0;
    end
    crc_new = {1'b0, crc[15:1]} ^ ((crc[0] ^ n_bit) ? 16'hA001 : 16'h0000);
  end

  // packet sequencer, bit timer, NRZI line driver
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_IDLE;
      clk_cnt            <= '0;
      bit_idx            <= 4'd0;
      len                <= 7'd0;
      bytes_left         <= 7'd0;
      pid                <= 4'd0;
      is_data            <= 1'b0;
      shift              <= 8'd0;
      crc                <= 16'd0;
      ones               <= 3'd0;
      lvl                <= 1'b1;
      dp_out             <= 1'b1;
      dm_out             <= 1'b0;
      tx_transfer_active <= 1'b0;
      get_tx_packet_data <= 1'b0;
      tx_error           <= 1'b0;
    end else begin
      get_tx_packet_data <= 1'b0;
      tx_error           <= 1'b0;
      if (state == S_IDLE) begin
        if (req_legal) begin
          if (req_data && (int'(buffer_occupancy) > MAX_PAYLOAD)) begin
            tx_error <= 1'b1;
          end else begin
            // first SYNC bit is a 0: the line leaves J for K right away
            state              <= S_SYNC;
            tx_transfer_active <= 1'b1;
            pid                <= req_pid;
            is_data            <= req_data;
            len                <= buffer_occupancy;
            bytes_left         <= buffer_occupancy;
            crc                <= 16'hFFFF;
            bit_idx            <= 4'd0;
            clk_cnt            <= CNT_TOP;
            ones               <= 3'd0;
            lvl                <= 1'b0;
            dp_out             <= 1'b0;
            dm_out             <= 1'b1;
          end
        end
      end else begin
        if (tx_packet != 3'd0) tx_error <= 1'b1;
        if (clk_cnt != '0) begin
          clk_cnt <= clk_cnt - 1'b1;
        end else begin
          clk_cnt <= CNT_TOP;
          state   <= n_state;
          bit_idx <= n_idx;
          case (n_kind)
            K_DATA: begin
              lvl    <= n_bit ? lvl : ~lvl;
              dp_out <= n_bit ? lvl : ~lvl;
              dm_out <= n_bit ? ~lvl : lvl;
              ones   <= n_bit ? ones + 3'd1 : 3'd0;
            end
            K_STUFF: begin
              lvl    <= ~lvl;
              dp_out <= ~lvl;
              dm_out <= lvl;
              ones   <= 3'd0;
            end
            K_SE0: begin
              dp_out <= 1'b0;
              dm_out <= 1'b0;
              ones   <= 3'd0;
            end
            default: begin
              lvl    <= 1'b1;
              dp_out <= 1'b1;
              dm_out <= 1'b0;
              ones   <= 3'd0;
            end
          endcase
          if (n_pop) begin
            get_tx_packet_data <= 1'b1;
            shift              <= tx_packet_data;
            bytes_left         <= bytes_left - 7'd1;
          end
          if (n_crc) crc <= crc_new;
          if (state == S_EOP_J) begin
            tx_transfer_active <= 1'b0;
            clk_cnt            <= '0;
          end
        end
      end
    end
  end

endmodule
